// File: rtl/key_debounce_cond.sv
// Push-button conditioning: per-key two-flop synchronizer and saturating debounce counter.
// Optional sticky press capture with irq is enabled by defining KEY_DEBOUNCE_COND_EDGE_CAPTURE_EN.
module key_debounce_cond #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_key,
    output logic [WIDTH-1:0] key_out,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse,
    input  logic [WIDTH-1:0] edge_clear,
    output logic [WIDTH-1:0] edge_capture,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic [WIDTH-1:0] press_q, press_d;
    logic [WIDTH-1:0] release_q, release_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    always_comb begin
        s1_d      = in_key;
        s2_d      = s1_q;
        key_d     = key_q;
        press_d   = '0;
        release_d = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != key_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    key_d[i]     = s2_q[i];
                    press_d[i]   = ~s2_q[i];
                    release_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q      <= '1;
            s2_q      <= '1;
            key_q     <= '1;
            press_q   <= '0;
            release_q <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            key_q     <= key_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign key_out       = key_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef KEY_DEBOUNCE_COND_EDGE_CAPTURE_EN
    logic [WIDTH-1:0] ecap_q, ecap_d;

    // Set term is ORed last so a press coinciding with a clear keeps the flag.
    always_comb begin
        ecap_d = (ecap_q & ~edge_clear) | press_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ecap_q <= '0;
        end else begin
            ecap_q <= ecap_d;
        end
    end

    assign edge_capture = ecap_q;
    assign irq          = |ecap_q;
`else
    logic unused_edge_clear;

    assign unused_edge_clear = ^edge_clear;
    assign edge_capture      = '0;
    assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_cond.sv
// Scoreboard bench for key_debounce_cond with WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_key_debounce_cond;

`ifdef KEY_DEBOUNCE_COND_EDGE_CAPTURE_EN
    localparam logic FEAT = 1'b1;
`else
    localparam logic FEAT = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic [3:0] in_key;
    logic [3:0] key_out;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] edge_clear;
    logic [3:0] edge_capture;
    logic       irq;

    key_debounce_cond #(
        .WIDTH(4),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in_key(in_key),
        .key_out(key_out),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .edge_clear(edge_clear),
        .edge_capture(edge_capture),
        .irq(irq)
    );

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] key;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   edge_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (edge_cnt < c) @(negedge clk);
    endtask

    // Drive a new raw level now; the accepted strobe is due 6 edges later.
    task automatic drive_expect(input logic [3:0] keys, input logic [3:0] p,
                                input logic [3:0] r, input logic [3:0] k);
        exp_t e;
        in_key = keys;
        e.cyc = edge_cnt + 6;
        e.press = p;
        e.rel = r;
        e.key = k;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && (press_pulse | release_pulse) != 4'h0) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got press=%0h release=%0h expected none (edge %0d)",
                         press_pulse, release_pulse, edge_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_cycle", edge_cnt, e.cyc);
                check("pulse_press", press_pulse, e.press);
                check("pulse_release", release_pulse, e.rel);
                check("pulse_key_out", key_out, e.key);
                check("pulse_exclusive", press_pulse & release_pulse, 4'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n    = 1'b1;
        in_key     = 4'hF;
        edge_clear = 4'h0;
        #2 reset_n = 1'b0;
        tick(3);
        check("reset_key_out", key_out, 4'hF);
        check("reset_press", press_pulse, 4'h0);
        check("reset_release", release_pulse, 4'h0);
        check("reset_irq", irq, 1'b0);
        check("reset_capture", edge_capture, 4'h0);
        reset_n = 1'b1;
        tick(2);

        // Clean press of key 0 with latency boundary checks
        drive_expect(4'hE, 4'h1, 4'h0, 4'hE);
        tick(5);
        check("press_not_yet", key_out, 4'hF);
        tick(1);
        check("press_key_out", key_out, 4'hE);
        check("press_pulse_high", press_pulse, 4'h1);
        tick(1);
        check("press_one_cycle", press_pulse, 4'h0);
        drive_expect(4'hF, 4'h0, 4'h1, 4'hF);
        tick(8);

        // Three-cycle glitch on key 1 is rejected; a later full press still needs full latency
        in_key = 4'hD;
        tick(3);
        in_key = 4'hF;
        tick(8);
        check("glitch_key_out", key_out, 4'hF);
        drive_expect(4'hD, 4'h2, 4'h0, 4'hD);
        tick(8);
        drive_expect(4'hF, 4'h0, 4'h2, 4'hF);
        tick(8);

        // Keys 2 and 3 together
        drive_expect(4'h3, 4'hC, 4'h0, 4'h3);
        tick(8);
        check("simul_key_out", key_out, 4'h3);
        drive_expect(4'hF, 4'h0, 4'hC, 4'hF);
        tick(8);
        check("simul_release_key_out", key_out, 4'hF);

        // Bounce train on key 0, then settle low
        for (int k = 0; k < 10; k++) begin
            in_key = (k % 2 == 0) ? 4'hE : 4'hF;
            tick(2);
        end
        check("bounce_key_out", key_out, 4'hF);
        drive_expect(4'hE, 4'h1, 4'h0, 4'hE);
        tick(8);
        drive_expect(4'hF, 4'h0, 4'h1, 4'hF);
        tick(8);

        // Reset mid-count with key 0 held through reset
        in_key = 4'hE;
        tick(3);
        reset_n = 1'b0;
        #1;
        check("midreset_key_out", key_out, 4'hF);
        check("midreset_press", press_pulse, 4'h0);
        check("midreset_irq", irq, 1'b0);
        tick(2);
        reset_n = 1'b1;
        drive_expect(4'hE, 4'h1, 4'h0, 4'hE);
        tick(8);
        check("postreset_key_out", key_out, 4'hE);

        // Edge capture (expected zero when the feature is compiled out)
        check("capture_set", edge_capture, {3'b000, FEAT});
        check("capture_irq", irq, FEAT);
        drive_expect(4'hF, 4'h0, 4'h1, 4'hF);
        tick(8);
        drive_expect(4'hE, 4'h1, 4'h0, 4'hE);
        wait_until(exp_q[exp_q.size()-1].cyc);
        edge_clear = 4'h1;
        tick(1);
        edge_clear = 4'h0;
        check("capture_set_wins", edge_capture, {3'b000, FEAT});
        edge_clear = 4'h1;
        tick(1);
        edge_clear = 4'h0;
        check("capture_cleared", edge_capture, 4'h0);
        check("capture_irq_cleared", irq, 1'b0);

        drive_expect(4'hF, 4'h0, 4'h1, 4'hF);
        tick(8);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
